// File: rtl/mux41_case.sv
// Registered 4:1 multiplexer with a valid qualifier carried alongside the data.
// Latency: 1 cycle from a valid input to y/out_valid.
// No backpressure: a new valid input is accepted on every clock edge.
module mux41_case #(
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_y;
    logic             r_vld;

    // Source select; any unresolved select value falls back to i0.
    always_comb begin
        w_mux = i0;
        case (sel)
            2'b00:   w_mux = i0;
            2'b01:   w_mux = i1;
            2'b10:   w_mux = i2;
            2'b11:   w_mux = i3;
            default: w_mux = i0;
        endcase
    end

    // Output register: data only loads on valid cycles, valid follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= RST_VAL;
            r_vld <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_y <= w_mux;
            end
        end
    end

    assign y         = r_y;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_mux41_case.sv
module tb_mux41_case;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n  = 1'b1;
    logic [1:0] sel    = 2'b00;
    logic       in_valid = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
    logic       b0 = 1'b0, b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;

    logic [7:0] y8, ya;
    logic       v8, va, y1, v1;

    int checks   = 0;
    int failures = 0;

    always #5 if (clk_en) clk = ~clk;

    mux41_case #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .i0(d0), .i1(d1), .i2(d2), .i3(d3),
        .sel(sel), .in_valid(in_valid), .y(y8), .out_valid(v8)
    );

    mux41_case #(.WIDTH(8), .RST_VAL(8'hA5)) ua (
        .clk(clk), .rst_n(rst_n), .i0(d0), .i1(d1), .i2(d2), .i3(d3),
        .sel(sel), .in_valid(in_valid), .y(ya), .out_valid(va)
    );

    mux41_case #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i0(b0), .i1(b1), .i2(b2), .i3(b3),
        .sel(sel), .in_valid(in_valid), .y(y1), .out_valid(v1)
    );

    typedef struct {
        logic [1:0] sel;
        logic       vld;
        logic [7:0] i0, i1, i2, i3;
        logic [7:0] exp_y;
        logic       exp_v;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] e6;

    initial begin
        // Stimulus table: sweep, hold on invalid, further patterns, end on 8'h44.
        vecs[0]  = '{2'b00, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 1'b1};
        vecs[1]  = '{2'b01, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22, 1'b1};
        vecs[2]  = '{2'b10, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h33, 1'b1};
        vecs[3]  = '{2'b11, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 1'b1};
        vecs[4]  = '{2'b10, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h33, 1'b1};
        vecs[5]  = '{2'b11, 1'b0, 8'h11, 8'h22, 8'h33, 8'hFF, 8'h33, 1'b0};
        vecs[6]  = '{2'b11, 1'b0, 8'h11, 8'h22, 8'h33, 8'hFF, 8'h33, 1'b0};
        vecs[7]  = '{2'b11, 1'b1, 8'h11, 8'h22, 8'h33, 8'hFF, 8'hFF, 1'b1};
        vecs[8]  = '{2'b00, 1'b1, 8'hA5, 8'h00, 8'hFF, 8'h0F, 8'hA5, 1'b1};
        vecs[9]  = '{2'b01, 1'b1, 8'hA5, 8'h5A, 8'hFF, 8'h0F, 8'h5A, 1'b1};
        vecs[10] = '{2'b00, 1'b0, 8'h99, 8'h5A, 8'hFF, 8'h0F, 8'h5A, 1'b0};
        vecs[11] = '{2'b11, 1'b1, 8'h01, 8'h02, 8'h03, 8'h44, 8'h44, 1'b1};

        // Reset with clock idle.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_idle_y8", y8, 8'h00);
        chk("rst_idle_v8", {7'd0, v8}, 8'h00);
        chk("rst_idle_ya", ya, 8'hA5);
        chk("rst_idle_y1", {7'd0, y1}, 8'h00);
        clk_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_y8", y8, 8'h00);
            chk("idle_v8", {7'd0, v8}, 8'h00);
            chk("idle_ya", ya, 8'hA5);
        end

        // WIDTH=1 sequence.
        b0 = 1'b1; b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; sel = 2'b00; in_valid = 1'b1;
        step();
        chk("w1_sel0_y", {7'd0, y1}, 8'h01);
        chk("w1_sel0_v", {7'd0, v1}, 8'h01);
        b0 = 1'b0; b1 = 1'b1; sel = 2'b01;
        step();
        chk("w1_sel1_y", {7'd0, y1}, 8'h01);
        sel = 2'b10;
        step();
        chk("w1_sel2_y", {7'd0, y1}, 8'h00);
        b3 = 1'b1; sel = 2'b11;
        step();
        chk("w1_sel3_y", {7'd0, y1}, 8'h01);

        // WIDTH=8 table.
        for (int k = 0; k < 12; k++) begin
            sel = vecs[k].sel; in_valid = vecs[k].vld;
            d0 = vecs[k].i0; d1 = vecs[k].i1; d2 = vecs[k].i2; d3 = vecs[k].i3;
            step();
            chk($sformatf("vec%0d_y", k), y8, vecs[k].exp_y);
            chk($sformatf("vec%0d_v", k), {7'd0, v8}, {7'd0, vecs[k].exp_v});
            chk($sformatf("vec%0d_ya", k), ya, vecs[k].exp_y);
        end

        // Mid-cycle input changes do not reach y; then async reset between edges.
        sel = 2'b00; d0 = 8'hEE; in_valid = 1'b1;
        #2;
        chk("midcycle_y", y8, 8'h44);
        rst_n = 1'b0;
        #1;
        chk("async_rst_y", y8, 8'h00);
        chk("async_rst_v", {7'd0, v8}, 8'h00);
        chk("async_rst_ya", ya, 8'hA5);
        step();
        chk("rst_hold_y", y8, 8'h00);
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        chk("post_rst_y", y8, 8'h00);
        chk("post_rst_v", {7'd0, v8}, 8'h00);
        in_valid = 1'b1; sel = 2'b10; d2 = 8'h3C;
        step();
        chk("post_rst_cap_y", y8, 8'h3C);
        chk("post_rst_cap_v", {7'd0, v8}, 8'h01);

        // Unresolved select falls back to i0 (two-state sims resolve sel to a value).
        d0 = 8'h77; d1 = 8'h81; d2 = 8'h82; d3 = 8'h83; sel = 2'bxx;
        #1;
        if ($isunknown(sel)) e6 = d0;
        else case (sel)
            2'b00: e6 = d0;
            2'b01: e6 = d1;
            2'b10: e6 = d2;
            default: e6 = d3;
        endcase
        step();
        chk("selx_y", y8, e6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
